// File: rtl/nbbpu_pkg.sv
// +-- nbbpu_pkg -- state encoding and memory-control bit positions shared by the sequencer
// +-- rev 1.0
`default_nettype none

package nbbpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_MEM_READ  = 3'd2,
    S_MEM_WRITE = 3'd3,
    S_EXECUTE   = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  localparam int MC_LOAD  = 0;
  localparam int MC_STORE = 1;

endpackage

`default_nettype wire

// File: rtl/nbbpu_watchdog.sv
// +-- nbbpu_watchdog -- counts stalled bus cycles and flags a timeout on the TIMEOUT_CYCLES-th one
// +-- rev 1.0
`default_nettype none

module nbbpu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic count_enable,
  input  logic clear,
  output logic timeout
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  assign timeout = count_enable && (count_q == LAST);

  always_ff @(posedge clock) begin
    if (!reset || clear || timeout) begin
      count_q <= '0;
    end else if (count_enable) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nbbpu_sequencer.sv
// +-- nbbpu_sequencer -- multi-cycle fetch/load/store sequencer with halt/step and bus watchdog
// +-- rev 1.0
`default_nettype none

module nbbpu_sequencer
  import nbbpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RESET_HALTED   = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cpu_PC,
  input  logic [3:0]               cpu_memory_control,
  input  logic [ADDRESS_WIDTH-1:0] cpu_ALU_result,
  input  logic [DATA_WIDTH-1:0]    cpu_write_data,
  output logic [DATA_WIDTH-1:0]    cpu_instruction,
  output logic [DATA_WIDTH-1:0]    cpu_read_data,
  output logic                     cpu_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic                     mem_request,
  output logic                     mem_write,
  input  logic                     mem_ready,
  input  logic                     halt,
  input  logic                     step,
  output logic                     halted,
  output logic                     bus_error
);

  state_e                  state_q, state_d;
  logic                    mem_request_q;
  logic                    mem_write_q;
  logic                    cpu_enable_q;
  logic                    halted_q;
  logic                    bus_error_q;
  logic                    step_q;
  logic [DATA_WIDTH-1:0]   cpu_instruction_q;
  logic [DATA_WIDTH-1:0]   cpu_read_data_q;
  logic                    w_accept;
  logic                    w_timeout;
  logic                    unused_mc_reserved;

  assign unused_mc_reserved = ^cpu_memory_control[3:2];
  assign w_accept           = mem_request_q && mem_ready;

  // Leaving a waiting state only happens on ready or timeout, so clearing on
  // ready / idle bus (and self-clearing on timeout) covers every state change.
  nbbpu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock       (clock),
    .reset       (reset),
    .count_enable(mem_request_q && !mem_ready),
    .clear       (mem_ready || !mem_request_q),
    .timeout     (w_timeout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     if (w_accept) state_d = S_DECODE;
      S_DECODE: begin
        if (cpu_memory_control[MC_STORE])     state_d = S_MEM_WRITE;
        else if (cpu_memory_control[MC_LOAD]) state_d = S_MEM_READ;
        else                                  state_d = S_EXECUTE;
      end
      S_MEM_READ,
      S_MEM_WRITE: if (w_accept) state_d = S_EXECUTE;
      S_EXECUTE:   state_d = (halt || step_q) ? S_HALTED : S_FETCH;
      S_HALTED:    if (!bus_error_q && (step || !halt)) state_d = S_FETCH;
      default:     state_d = S_HALTED;
    endcase
    if (w_timeout) state_d = S_HALTED;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= RESET_HALTED ? S_HALTED : S_FETCH;
      mem_request_q     <= 1'b0;
      mem_write_q       <= 1'b0;
      cpu_enable_q      <= 1'b0;
      halted_q          <= RESET_HALTED;
      bus_error_q       <= 1'b0;
      step_q            <= 1'b0;
      cpu_instruction_q <= '0;
      cpu_read_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_request_q <= (state_d == S_FETCH) || (state_d == S_MEM_READ) || (state_d == S_MEM_WRITE);
      mem_write_q   <= (state_d == S_MEM_WRITE);
      cpu_enable_q  <= (state_d == S_EXECUTE);
      halted_q      <= (state_d == S_HALTED);
      if (w_timeout) bus_error_q <= 1'b1;
      if (state_q == S_FETCH && w_accept) cpu_instruction_q <= mem_read_data;
      if (state_q == S_MEM_READ && w_accept) cpu_read_data_q <= mem_read_data;
      if (state_q == S_HALTED && state_d == S_FETCH) step_q <= step;
      else if (state_d == S_HALTED)                  step_q <= 1'b0;
    end
  end

  // Address and data come straight from the core, which only changes them on cpu_enable.
  assign mem_address     = !mem_request_q ? '0 :
                           (state_q == S_FETCH) ? cpu_PC : cpu_ALU_result;
  assign mem_write_data  = (mem_request_q && mem_write_q) ? cpu_write_data : '0;
  assign mem_request     = mem_request_q;
  assign mem_write       = mem_write_q;
  assign cpu_enable      = cpu_enable_q;
  assign halted          = halted_q;
  assign bus_error       = bus_error_q;
  assign cpu_instruction = cpu_instruction_q;
  assign cpu_read_data   = cpu_read_data_q;

endmodule

`default_nettype wire

// File: tb/tb_nbbpu_sequencer.sv
// +-- tb_nbbpu_sequencer -- cycle-by-cycle check of the sequencer against a phase-level timeline model
// +-- rev 1.0
`default_nettype none

module tb_nbbpu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_PC = '0, cpu_ALU_result = '0, cpu_write_data = '0, mem_read_data = '0;
  logic [3:0]  cpu_memory_control = '0;
  logic        mem_ready = 1'b0, halt = 1'b0, step = 1'b0;
  logic [15:0] cpu_instruction, cpu_read_data, mem_address, mem_write_data;
  logic        cpu_enable, mem_request, mem_write, halted, bus_error;

  always #5 clock = ~clock;

  nbbpu_sequencer #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(4), .RESET_HALTED(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .cpu_PC(cpu_PC), .cpu_memory_control(cpu_memory_control),
    .cpu_ALU_result(cpu_ALU_result), .cpu_write_data(cpu_write_data),
    .cpu_instruction(cpu_instruction), .cpu_read_data(cpu_read_data), .cpu_enable(cpu_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_request(mem_request), .mem_write(mem_write), .mem_ready(mem_ready),
    .halt(halt), .step(step), .halted(halted), .bus_error(bus_error)
  );

  // One entry per clock cycle: what the bench drives and what the outputs must be.
  typedef struct {
    logic        rst, rdy, hlt_in, stp;
    logic [15:0] rdata, pc, alu, wd;
    logic [3:0]  mc;
    bit          chk;
    logic        req, we, en, hl, be;
    logic [15:0] addr, wdat, instr, rd;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc, m_alu, m_wd, m_instr, m_rd;
  logic [3:0]  m_mc;
  logic        m_halt, m_be;
  int          checks = 0, errors = 0;
  int          n_en = 0, n_wr = 0, first_en = -1;
  logic [15:0] en_rd[$], wr_addr[$], wr_data[$];

  task automatic push(input logic rst, input logic rdy, input logic [15:0] rdata, input logic stp,
                      input bit chk, input logic req, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdat, input logic en, input logic hl);
    ent_t e;
    e.rst = rst; e.rdy = rdy; e.rdata = rdata; e.stp = stp; e.hlt_in = m_halt;
    e.pc = m_pc; e.alu = m_alu; e.wd = m_wd; e.mc = m_mc;
    e.chk = chk; e.req = req; e.we = we; e.addr = addr; e.wdat = wdat; e.en = en; e.hl = hl;
    e.be = m_be; e.instr = m_instr; e.rd = m_rd;
    q.push_back(e);
  endtask

  task automatic idle_zero(input logic rst);
    push(rst, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic halted_n(input int n, input int step_at);
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b0, 16'h0, (i == step_at), 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  // Bus access of n wait cycles followed by the completing cycle.
  task automatic access(input int nwait, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdat, input logic [15:0] rdata);
    for (int i = 0; i < nwait; i++)
      push(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, we, addr, wdat, 1'b0, 1'b0);
    push(1'b1, 1'b1, rdata, 1'b0, 1'b1, 1'b1, we, addr, wdat, 1'b0, 1'b0);
  endtask

  // Whole instruction: fetch, decode, optional data access, execute; core PC advances after.
  task automatic instr(input logic [15:0] word, input logic [3:0] mc, input logic [15:0] alu,
                       input logic [15:0] wd, input int wf, input int wdw,
                       input logic [15:0] ld, input int halt_at);
    m_mc = mc; m_alu = alu; m_wd = wd;
    for (int i = 0; i <= wf; i++) begin
      if (i == halt_at) m_halt = 1'b1;
      push(1'b1, (i == wf), (i == wf) ? word : 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, m_pc, 16'h0, 1'b0, 1'b0);
    end
    m_instr = word;
    idle_zero(1'b1);
    if (mc[1]) begin
      access(wdw, 1'b1, alu, wd, 16'h0);
    end else if (mc[0]) begin
      access(wdw, 1'b0, alu, 16'h0, ld);
      m_rd = ld;
    end
    push(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    m_pc = m_pc + 16'd1;
  endtask

  task automatic model_reset();
    m_instr = '0; m_rd = '0; m_be = 1'b0;
  endtask

  task automatic cmp(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    ent_t e;
    int   idx;
    m_pc = '0; m_alu = '0; m_wd = '0; m_mc = '0; m_halt = 1'b0;
    model_reset();

    // Reset, then one idle cycle before the first fetch request.
    push(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    idle_zero(1'b0); idle_zero(1'b0);
    idle_zero(1'b1);
    instr(16'h1123, 4'b0000, 16'h0000, 16'h0000, 0, 0, 16'h0, -1);   // ALU at PC 0
    instr(16'h2140, 4'b0001, 16'h0040, 16'h0000, 0, 3, 16'h1234, -1); // load, 3 waits
    instr(16'h3280, 4'b0010, 16'h0080, 16'hBEEF, 1, 2, 16'h0, -1);    // store
    instr(16'h4F00, 4'b1111, 16'h00A0, 16'h5A5A, 0, 0, 16'h0, -1);    // load+store: store wins
    instr(16'h5C00, 4'b1100, 16'h00C0, 16'h7777, 0, 0, 16'h0, -1);    // reserved bits only
    instr(16'h6000, 4'b0000, 16'h0000, 16'h0000, 2, 0, 16'h0, 1);     // halt mid-fetch
    halted_n(3, 2);
    instr(16'h7000, 4'b0000, 16'h0000, 16'h0000, 0, 0, 16'h0, -1);    // single step
    halted_n(2, -1);
    m_halt = 1'b0;
    halted_n(1, -1);
    instr(16'h8000, 4'b0000, 16'h0000, 16'h0000, 0, 0, 16'h0, -1);

    // Load interrupted by reset while waiting on data.
    m_mc = 4'b0001; m_alu = 16'h0044;
    push(1'b1, 1'b1, 16'h9100, 1'b0, 1'b1, 1'b1, 1'b0, m_pc, 16'h0, 1'b0, 1'b0);
    m_instr = 16'h9100;
    idle_zero(1'b1);
    push(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0, 1'b0, 1'b0);
    model_reset();
    idle_zero(1'b0);
    idle_zero(1'b1);
    instr(16'hA000, 4'b0000, 16'h0000, 16'h0000, 0, 0, 16'h0, -1);

    // Fetch never completes: watchdog fires after 4 stalled cycles.
    m_mc = 4'b0000;
    for (int i = 0; i < 4; i++)
      push(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, m_pc, 16'h0, 1'b0, 1'b0);
    m_be = 1'b1;
    halted_n(2, 1);
    m_halt = 1'b1;
    halted_n(3, 0);

    idx = 0;
    while (q.size() > 0) begin
      @(negedge clock);
      e = q.pop_front();
      reset = e.rst; mem_ready = e.rdy; mem_read_data = e.rdata; halt = e.hlt_in; step = e.stp;
      cpu_PC = e.pc; cpu_memory_control = e.mc; cpu_ALU_result = e.alu; cpu_write_data = e.wd;
      #1;
      if (e.chk) begin
        cmp("mem_request", idx, 16'(mem_request), 16'(e.req));
        cmp("mem_write", idx, 16'(mem_write), 16'(e.we));
        cmp("mem_address", idx, mem_address, e.addr);
        cmp("mem_write_data", idx, mem_write_data, e.wdat);
        cmp("cpu_enable", idx, 16'(cpu_enable), 16'(e.en));
        cmp("halted", idx, 16'(halted), 16'(e.hl));
        cmp("bus_error", idx, 16'(bus_error), 16'(e.be));
        cmp("cpu_instruction", idx, cpu_instruction, e.instr);
        cmp("cpu_read_data", idx, cpu_read_data, e.rd);
      end
      if (cpu_enable === 1'b1) begin
        n_en++;
        if (first_en < 0) first_en = idx;
        en_rd.push_back(cpu_read_data);
      end
      if (mem_request === 1'b1 && mem_write === 1'b1 && e.rdy) begin
        n_wr++;
        wr_addr.push_back(mem_address);
        wr_data.push_back(mem_write_data);
      end
      idx++;
    end

    // Hand-computed anchors for the timeline model.
    cmp("first_enable_cycle", idx, 16'(first_en), 16'd6);
    cmp("enable_count", idx, 16'(n_en), 16'd9);
    cmp("write_count", idx, 16'(n_wr), 16'd2);
    cmp("load_data_at_enable", idx, (en_rd.size() > 1) ? en_rd[1] : 16'hXXXX, 16'h1234);
    cmp("store_addr", idx, (wr_addr.size() > 0) ? wr_addr[0] : 16'hXXXX, 16'h0080);
    cmp("store_data", idx, (wr_data.size() > 0) ? wr_data[0] : 16'hXXXX, 16'hBEEF);
    cmp("both_bits_addr", idx, (wr_addr.size() > 1) ? wr_addr[1] : 16'hXXXX, 16'h00A0);
    cmp("final_bus_error", idx, 16'(bus_error), 16'd1);
    cmp("final_halted", idx, 16'(halted), 16'd1);
    cmp("final_request", idx, 16'(mem_request), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
